camellia_mode_ctrl: RTL and testbench
=====================================

Name: camellia_mode_ctrl

Overview:
Parametrised successor to the fixed enc/dec Camellia top. It adds block-chaining modes (ECB/CBC), a per-block direction select, and a 192/256-bit key path. It also adds valid/ready handshakes on both data sides and a block counter. It drives one external Camellia core through a start/done handshake and owns the IV/chaining register, so a single core serves both directions.

Parameters:
KEY_W, 128, key width; legal 128/192/256, passed unchanged to core_key
CNT_W, 16, width of blk_cnt
TIMEOUT_CYCLES, 64, core watchdog limit in cycles (used only with the optional feature)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
in_valid  in  1  input block valid
in_ready  out  1  block accepted when in_valid&&in_ready
in_data  in  128  plaintext (enc) or ciphertext (dec)
in_dir  in  1  0=encrypt, 1=decrypt; sampled at accept
in_mode  in  1  0=ECB, 1=CBC; sampled at accept
KL  in  KEY_W  key; sampled at accept
iv_load  in  1  load iv_in into chain register (honoured in IDLE only)
iv_in  in  128  initial vector
out_valid  out  1  result valid
out_ready  in  1  downstream accept
out_data  out  128  result block
core_start  out  1  one-cycle start pulse to core
core_dir  out  1  direction to core
core_key  out  KEY_W  key to core
core_in  out  128  block to core
core_done  in  1  core result valid (one-cycle pulse)
core_out  in  128  core result
blk_cnt  out  CNT_W  completed-block count
busy  out  1  high in every state except IDLE
err_timeout  out  1  one-cycle watchdog pulse

Behaviour:
- Reset (RST high at an edge) forces the following; it overrides all other activity, including mid-operation:
  - state=IDLE
  - out_valid=0, out_data=0, core_start=0, err_timeout=0, blk_cnt=0, chain=0
  - registered core_in, core_key, core_dir = 0
  - A core_done arriving after reset is ignored.
- States: IDLE -> START -> WAIT -> OUT -> IDLE.
- IDLE:
  - in_ready=1 (combinational from state).
  - iv_load loads chain<=iv_in.
  - If iv_load and accept occur in the same cycle, the block uses iv_in as its chain value.
- On accept:
  - Latch in_data, in_dir, in_mode and KL.
  - core_in <= (mode=CBC && dir=enc) ? in_data ^ chainval : in_data.
  - Go to START.
- START:
  - core_start=1 for exactly one cycle; core_in, core_key and core_dir are stable from START until core_done.
  - Go to WAIT.
  - iv_load is ignored in all non-IDLE states.
- WAIT:
  - On core_done, capture the result and go to OUT:
    - ECB: out_data<=core_out; chain unchanged.
    - CBC enc: out_data<=core_out; chain<=core_out.
    - CBC dec: out_data<=core_out^chain; chain<=latched ciphertext.
  - core_done in any state other than WAIT is ignored.
- OUT:
  - out_valid=1 with out_data held until out_ready.
  - On out_valid&&out_ready: blk_cnt++ (wraps 2^CNT_W-1 -> 0), go to IDLE.
  - in_ready=0, so a new block is never accepted in the same cycle as the output handshake.
- Latency: accept at edge 0 -> core_start in cycle 1 -> core_done at cycle 1+L (L>=1) -> out_valid at cycle 2+L.
  - Throughput: one block per L+3 cycles with out_ready held high.
- Mixing modes and directions between blocks is legal.
  - The chain register is shared; switching direction in CBC without iv_load is the user's responsibility and is not detected.

Optional Feature:
Macro CAMELLIA_CORE_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without core_done: err_timeout=1 for one cycle, go to IDLE.
  - On timeout: chain, out_data and blk_cnt are unchanged, and no out_valid is raised.
  - core_done in the same cycle as the limit counts as success.
- Not defined:
  - WAIT waits indefinitely.
  - err_timeout is tied to 0 and the counter logic is absent.

Test Plan:
1. ECB enc, KL=0123456789abcdeffedcba9876543210, in_data=same value -> out_data=67673138549669730857065648eabe43, blk_cnt=1, out_valid at cycle 2+L.
2. ECB dec of 67673138549669730857065648eabe43 with the same key -> 0123456789abcdeffedcba9876543210.
3. CBC enc with IV=0, two identical blocks P1=P2=0123..3210 -> C1=6767..be43, C2=E(P2^C1), so C2≠C1; then iv_load of 0 and CBC dec of C1,C2 -> P1,P2 recovered.
4. Backpressure: hold out_ready=0 for 10 cycles -> out_data stable, in_ready=0, no second core_start; release -> one handshake and blk_cnt increments by exactly 1.
5. RST asserted in WAIT, then a late core_done -> all outputs at reset values, no out_valid, chain=0, next block processed normally.
6. With CAMELLIA_CORE_TIMEOUT_EN and TIMEOUT_CYCLES=8, core never responds -> err_timeout pulses 8 cycles after WAIT entry, returns to IDLE, blk_cnt unchanged; without the macro -> busy stays high.

Source files
------------

// File: rtl/camellia_mode_ctrl.sv
// ECB/CBC mode controller wrapping one external Camellia core over a start/done handshake.
// Optional core watchdog is enabled by defining CAMELLIA_CORE_TIMEOUT_EN.
module camellia_mode_ctrl #(
  parameter int KEY_W          = 128,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [127:0]       in_data,
  input  logic               in_dir,
  input  logic               in_mode,
  input  logic [KEY_W-1:0]   KL,
  input  logic               iv_load,
  input  logic [127:0]       iv_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [127:0]       out_data,
  output logic               core_start,
  output logic               core_dir,
  output logic [KEY_W-1:0]   core_key,
  output logic [127:0]       core_in,
  input  logic               core_done,
  input  logic [127:0]       core_out,
  output logic [CNT_W-1:0]   blk_cnt,
  output logic               busy,
  output logic               err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_OUT
  } state_t;

  state_t             state_q, state_d;
  logic [127:0]       chain_q, chain_d;
  logic [127:0]       ct_q, ct_d;
  logic               mode_q, mode_d;
  logic [127:0]       out_data_q, out_data_d;
  logic [127:0]       core_in_q, core_in_d;
  logic [KEY_W-1:0]   core_key_q, core_key_d;
  logic               core_dir_q, core_dir_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [127:0]       chain_sel;
  logic               accept;

`ifdef CAMELLIA_CORE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic               err_timeout_q, err_timeout_d;
`endif

  assign accept    = in_valid && (state_q == S_IDLE);
  // A same-cycle iv_load takes effect for the block being accepted.
  assign chain_sel = iv_load ? iv_in : chain_q;

  always_comb begin
    state_d    = state_q;
    chain_d    = chain_q;
    ct_d       = ct_q;
    mode_d     = mode_q;
    out_data_d = out_data_q;
    core_in_d  = core_in_q;
    core_key_d = core_key_q;
    core_dir_d = core_dir_q;
    blk_cnt_d  = blk_cnt_q;
`ifdef CAMELLIA_CORE_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    err_timeout_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (iv_load) begin
          chain_d = iv_in;
        end
        if (accept) begin
          ct_d       = in_data;
          mode_d     = in_mode;
          core_dir_d = in_dir;
          core_key_d = KL;
          core_in_d  = (in_mode && !in_dir) ? (in_data ^ chain_sel) : in_data;
          state_d    = S_START;
        end
      end
      S_START: begin
`ifdef CAMELLIA_CORE_TIMEOUT_EN
        to_cnt_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          state_d = S_OUT;
          if (!mode_q) begin
            out_data_d = core_out;
          end else if (!core_dir_q) begin
            out_data_d = core_out;
            chain_d    = core_out;
          end else begin
            out_data_d = core_out ^ chain_q;
            chain_d    = ct_q;
          end
        end
`ifdef CAMELLIA_CORE_TIMEOUT_EN
        // core_done on the limit cycle wins over the watchdog.
        else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      S_OUT: begin
        if (out_ready) begin
          blk_cnt_d = blk_cnt_q + CNT_W'(1);
          state_d   = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      chain_q    <= '0;
      ct_q       <= '0;
      mode_q     <= 1'b0;
      out_data_q <= '0;
      core_in_q  <= '0;
      core_key_q <= '0;
      core_dir_q <= 1'b0;
      blk_cnt_q  <= '0;
`ifdef CAMELLIA_CORE_TIMEOUT_EN
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      chain_q    <= chain_d;
      ct_q       <= ct_d;
      mode_q     <= mode_d;
      out_data_q <= out_data_d;
      core_in_q  <= core_in_d;
      core_key_q <= core_key_d;
      core_dir_q <= core_dir_d;
      blk_cnt_q  <= blk_cnt_d;
`ifdef CAMELLIA_CORE_TIMEOUT_EN
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  assign in_ready   = (state_q == S_IDLE);
  assign core_start = (state_q == S_START);
  assign out_valid  = (state_q == S_OUT);
  assign busy       = (state_q != S_IDLE);
  assign out_data   = out_data_q;
  assign core_in    = core_in_q;
  assign core_key   = core_key_q;
  assign core_dir   = core_dir_q;
  assign blk_cnt    = blk_cnt_q;

`ifdef CAMELLIA_CORE_TIMEOUT_EN
  assign err_timeout = err_timeout_q;
`else
  // Watchdog absent: constant low (the comparison is never true).
  assign err_timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_camellia_mode_ctrl.sv
// Directed self-checking bench for camellia_mode_ctrl with a toy stand-in core
// that returns the published Camellia-128 vector for the reference key/block.
module tb_camellia_mode_ctrl;

  localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] CT  = 128'h67673138549669730857065648eabe43;
  localparam logic [127:0] IVX = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] IVY = 128'hdeadbeef0badf00dcafebabe12345678;

  logic         CLK, RST;
  logic         in_valid, in_ready, in_dir, in_mode, iv_load;
  logic [127:0] in_data, KL, iv_in;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         core_start, core_dir;
  logic [127:0] core_key, core_in;
  logic         core_done = 1'b0;
  logic [127:0] core_out  = '0;
  logic [15:0]  blk_cnt;
  logic         busy, err_timeout;

  int checks = 0;
  int errors = 0;
  int core_lat = 3;
  bit core_en = 1'b1;
  int start_cnt = 0;
  logic         core_pend = 1'b0;
  int           core_cnt  = 0;
  logic [127:0] core_res  = '0;

  camellia_mode_ctrl #(.KEY_W(128), .CNT_W(16), .TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dir(in_dir), .in_mode(in_mode), .KL(KL),
    .iv_load(iv_load), .iv_in(iv_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .core_start(core_start), .core_dir(core_dir), .core_key(core_key), .core_in(core_in),
    .core_done(core_done), .core_out(core_out),
    .blk_cnt(blk_cnt), .busy(busy), .err_timeout(err_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Toy invertible cipher: rotate-left-13 then key xor, except the reference vector pair.
  function automatic logic [127:0] toyEnc(input logic [127:0] x, input logic [127:0] k);
    if (x == PT && k == KEY) return CT;
    return {x[114:0], x[127:115]} ^ k;
  endfunction

  function automatic logic [127:0] toyDec(input logic [127:0] y, input logic [127:0] k);
    logic [127:0] t;
    if (y == CT && k == KEY) return PT;
    t = y ^ k;
    return {t[12:0], t[127:13]};
  endfunction

  // Stand-in core: done arrives core_lat cycles after the start cycle; ignores RST.
  always @(posedge CLK) begin
    core_done <= 1'b0;
    if (core_start) start_cnt <= start_cnt + 1;
    if (core_start && core_en) begin
      if (core_lat <= 1) begin
        core_done <= 1'b1;
        core_out  <= core_dir ? toyDec(core_in, core_key) : toyEnc(core_in, core_key);
      end else begin
        core_pend <= 1'b1;
        core_cnt  <= core_lat - 1;
        core_res  <= core_dir ? toyDec(core_in, core_key) : toyEnc(core_in, core_key);
      end
    end else if (core_pend) begin
      if (core_cnt == 1) begin
        core_done <= 1'b1;
        core_out  <= core_res;
        core_pend <= 1'b0;
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one block, waits for the result, optionally stalls out_ready, then handshakes.
  task automatic applyStimulus(input logic [127:0] data, input logic dir, input logic mode,
                               input logic ld, input logic [127:0] iv, input int hold,
                               output logic [127:0] res, output int lat);
    int n;
    int starts0;
    logic stable;
    in_data = data; in_dir = dir; in_mode = mode; iv_load = ld; iv_in = iv; KL = KEY;
    in_valid = 1'b1;
    starts0 = start_cnt;
    checkOutput("in_ready_idle", 128'(in_ready), 128'(1));
    @(posedge CLK); #1;
    in_valid = 1'b0; iv_load = 1'b0; in_data = ~data; KL = '0; in_dir = ~dir; in_mode = ~mode;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    lat = n + 1;
    if (!out_valid) begin
      checkOutput("out_valid_wait", 128'(0), 128'(1));
      res = '0;
      return;
    end
    res = out_data;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; iv_load = 1'b1; iv_in = ~iv;
      @(posedge CLK); #1;
      if (out_data !== res || !out_valid || in_ready) stable = 1'b0;
    end
    in_valid = 1'b0; iv_load = 1'b0;
    if (hold > 0) checkOutput("hold_stable", 128'(stable), 128'(1));
    out_ready = 1'b1;
    @(posedge CLK); #1;
    out_ready = 1'b0;
    checkOutput("start_pulses", 128'(start_cnt - starts0), 128'(1));
    checkOutput("post_hs_valid", 128'(out_valid), 128'(0));
  endtask

  initial begin
    logic [127:0] r, c1, c2, cy;
    int lat, n;
    logic seen_ov, seen_to;

    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    logic [127:0] r, c1, c2, cy;
    int lat, n;
    logic seen_ov, seen_to;

    RST = 1'b1; in_valid = 1'b0; in_data = '0; in_dir = 1'b0; in_mode = 1'b0;
    KL = '0; iv_load = 1'b0; iv_in = '0; out_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    checkOutput("rst_out_valid", 128'(out_valid), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    checkOutput("rst_blk_cnt", 128'(blk_cnt), 128'(0));
    checkOutput("rst_core_start", 128'(core_start), 128'(0));
    checkOutput("rst_err_timeout", 128'(err_timeout), 128'(0));
    checkOutput("rst_out_data", out_data, 128'(0));
    checkOutput("rst_core_in", core_in, 128'(0));

    // ECB encrypt of the reference vector, L=3
    core_lat = 3;
    applyStimulus(PT, 1'b0, 1'b0, 1'b0, '0, 0, r, lat);
    checkOutput("ecb_enc_data", r, CT);
    checkOutput("ecb_enc_lat", 128'(lat), 128'(5));
    checkOutput("ecb_enc_cnt", 128'(blk_cnt), 128'(1));

    // ECB decrypt, L=1
    core_lat = 1;
    applyStimulus(CT, 1'b1, 1'b0, 1'b0, '0, 0, r, lat);
    checkOutput("ecb_dec_data", r, PT);
    checkOutput("ecb_dec_lat", 128'(lat), 128'(3));

    // CBC encrypt two identical blocks from IV=0, then decrypt them back
    core_lat = 2;
    applyStimulus(PT, 1'b0, 1'b1, 1'b1, '0, 0, c1, lat);
    checkOutput("cbc_enc_c1", c1, CT);
    applyStimulus(PT, 1'b0, 1'b1, 1'b0, '0, 0, c2, lat);
    checkOutput("cbc_enc_c2", c2, toyEnc(PT ^ CT, KEY));
    applyStimulus(c1, 1'b1, 1'b1, 1'b1, '0, 0, r, lat);
    checkOutput("cbc_dec_p1", r, PT);
    applyStimulus(c2, 1'b1, 1'b1, 1'b0, '0, 0, r, lat);
    checkOutput("cbc_dec_p2", r, PT);
    checkOutput("cbc_cnt", 128'(blk_cnt), 128'(6));

    // iv_load in the accept cycle, then iv_load alone in IDLE
    applyStimulus(PT, 1'b0, 1'b1, 1'b1, IVX, 0, r, lat);
    checkOutput("cbc_iv_same_cycle", r, toyEnc(PT ^ IVX, KEY));
    iv_load = 1'b1; iv_in = IVY;
    @(posedge CLK); #1;
    iv_load = 1'b0;
    applyStimulus(PT, 1'b0, 1'b1, 1'b0, '0, 0, cy, lat);
    checkOutput("cbc_iv_idle_load", cy, toyEnc(PT ^ IVY, KEY));

    // Backpressure on an ECB block; stray iv_load during OUT must be ignored
    applyStimulus(IVX, 1'b0, 1'b0, 1'b0, '0, 10, r, lat);
    checkOutput("bp_data", r, toyEnc(IVX, KEY));
    checkOutput("bp_cnt", 128'(blk_cnt), 128'(9));
    applyStimulus(PT, 1'b0, 1'b1, 1'b0, '0, 0, r, lat);
    checkOutput("chain_kept", r, toyEnc(PT ^ cy, KEY));

    // Reset while waiting on the core; its late done must be ignored
    core_lat = 6;
    in_data = PT; in_dir = 1'b0; in_mode = 1'b1; iv_load = 1'b1; iv_in = IVX; KL = KEY;
    in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; iv_load = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    checkOutput("busy_in_wait", 128'(busy), 128'(1));
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    checkOutput("midrst_busy", 128'(busy), 128'(0));
    checkOutput("midrst_blk_cnt", 128'(blk_cnt), 128'(0));
    checkOutput("midrst_out_data", out_data, 128'(0));
    checkOutput("midrst_core_in", core_in, 128'(0));
    checkOutput("midrst_core_key", core_key, 128'(0));
    seen_ov = 1'b0;
    repeat (8) begin
      @(posedge CLK); #1;
      if (out_valid || busy) seen_ov = 1'b1;
    end
    checkOutput("late_done_ignored", 128'(seen_ov), 128'(0));
    applyStimulus(PT, 1'b0, 1'b1, 1'b0, '0, 0, r, lat);
    checkOutput("post_rst_chain0", r, CT);
    checkOutput("post_rst_lat", 128'(lat), 128'(8));
    checkOutput("post_rst_cnt", 128'(blk_cnt), 128'(1));

    // Core never answers
    core_en = 1'b0;
    in_data = PT; in_dir = 1'b0; in_mode = 1'b0; KL = KEY; in_valid = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    n = 0; seen_ov = 1'b0; seen_to = 1'b0;
    while (!seen_to && n < 40) begin
      @(posedge CLK); #1;
      n++;
      if (out_valid) seen_ov = 1'b1;
      if (err_timeout) seen_to = 1'b1;
    end
`ifdef CAMELLIA_CORE_TIMEOUT_EN
    checkOutput("to_seen", 128'(seen_to), 128'(1));
    checkOutput("to_cycle", 128'(n + 1), 128'(10));
    checkOutput("to_idle", 128'(busy), 128'(0));
    @(posedge CLK); #1;
    checkOutput("to_one_cycle", 128'(err_timeout), 128'(0));
`else
    checkOutput("no_to_seen", 128'(seen_to), 128'(0));
    checkOutput("no_to_busy", 128'(busy), 128'(1));
`endif
    checkOutput("to_no_out_valid", 128'(seen_ov), 128'(0));
    checkOutput("to_cnt_kept", 128'(blk_cnt), 128'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
